// File: rtl/request_unit_if.sv
// Decoder/cache-facing bundle of the request unit: decoded flags and hits in,
// memory requests, PC enable and status out.
interface request_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             memtoReg;
  logic             memWr;
  logic             halt;
  logic             ihit;
  logic             dhit;
  logic             iREN;
  logic             dREN;
  logic             dWEN;
  logic             pc_en;
  logic             halted;
  logic [CNT_W-1:0] instr_count;
  logic             wdog_err;

  modport master (
    input  memtoReg, memWr, halt, ihit, dhit,
    output iREN, dREN, dWEN, pc_en, halted, instr_count, wdog_err
  );

  modport slave (
    output memtoReg, memWr, halt, ihit, dhit,
    input  iREN, dREN, dWEN, pc_en, halted, instr_count, wdog_err
  );
endinterface

// File: rtl/request_unit.sv
// Memory-request sequencer: one outstanding access, sticky halt, retire counter.
// Optional data-phase watchdog enabled with `define REQ_WATCHDOG_EN.
module request_unit #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  request_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  logic             dren_q;
  logic             dwen_q;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;
  logic             mem_op;
  logic             pc_en_c;

  assign mem_op = bus.memtoReg | bus.memWr;

  // Retire strobe: same cycle as the completing ihit (non-mem) or dhit (mem).
  always_comb begin
    pc_en_c = 1'b0;
    case (state)
      FETCH:   pc_en_c = bus.ihit & ~bus.halt & ~mem_op;
      DATA:    pc_en_c = bus.dhit;
      default: pc_en_c = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FETCH;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.ihit) begin
            if (bus.halt) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end else if (mem_op) begin
              // Store takes precedence when both flags are decoded.
              state  <= DATA;
              dren_q <= bus.memtoReg & ~bus.memWr;
              dwen_q <= bus.memWr;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (bus.dhit) begin
            state   <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            count_q <= count_q + CNT_W'(1);
          end
        end
        HALTED: begin
          dren_q <= 1'b0;
          dwen_q <= 1'b0;
        end
        default: begin
          state  <= FETCH;
          dren_q <= 1'b0;
          dwen_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iREN        = (state == FETCH);
  assign bus.dREN        = dren_q;
  assign bus.dWEN        = dwen_q;
  assign bus.pc_en       = pc_en_c;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

`ifdef REQ_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_q;
  logic              data_entry;
  logic              data_stall;

  assign data_entry = (state == FETCH) & bus.ihit & ~bus.halt & mem_op;
  assign data_stall = (state == DATA) & ~bus.dhit;

  // Counts stalled DATA cycles; error is sticky and does not disturb the FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      if (data_entry) begin
        wdog_cnt <= '0;
      end else if (data_stall && (wdog_cnt != WDOG_W'(WDOG_LIMIT))) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
      if (data_stall && (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1))) begin
        wdog_q <= 1'b1;
      end
    end
  end

  assign bus.wdog_err = wdog_q;
`else
  // WDOG_LIMIT stays referenced so the parameter set is identical in both builds.
  assign bus.wdog_err = (WDOG_LIMIT == 0) && 1'b0;
`endif

endmodule
